// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state enum and address-field width helpers for dcache_dm
package dcache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_REFILL
  } state_e;

  function automatic int word_sel_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int offset_w(input int words);
    return 2 + $clog2(words);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 32 - offset_w(words) - index_w(lines);
  endfunction

  function automatic int line_w(input int words);
    return WORD_W * words;
  endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// rtl/dcache_dm_if.sv - line-wide req/ack bus between dcache_dm (master) and main memory (slave)
interface dcache_dm_if #(
  parameter int WORDS = 4
);
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [32*WORDS-1:0]   mem_wline;
  logic [32*WORDS-1:0]   mem_rline;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wline,
    input  mem_rline, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wline,
    output mem_rline, mem_ack
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - miss FSM and memory handshake for dcache_dm
// Optional DCACHE_PERF_CNT_EN adds hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        access,
  input  logic        hit,
  input  logic        victim_dirty,
  input  logic [31:0] req_line_addr,
  input  logic [31:0] victim_line_addr,
  input  logic        mem_ack,
  output state_e      state,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic        fill
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (access && !hit) begin
          mem_req_d = 1'b1;
          if (victim_dirty) begin
            state_d    = ST_WB;
            mem_we_d   = 1'b1;
            mem_addr_d = victim_line_addr;
          end else begin
            state_d    = ST_REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = req_line_addr;
          end
        end
      end
      ST_WB: begin
        // Request stays up across the WB->REFILL hand-off; only direction and address change.
        if (mem_ack) begin
          state_d    = ST_REFILL;
          mem_we_d   = 1'b0;
          mem_addr_d = req_line_addr;
        end
      end
      ST_REFILL: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign state    = state_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign fill     = (state_q == ST_REFILL) && mem_ack;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        replay_q, replay_d;

  // replay_q marks the IDLE cycle right after a fill so the replayed hit is not counted.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    replay_d   = replay_q;
    if (state_q == ST_IDLE) begin
      replay_d = 1'b0;
      if (access && hit && !replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
      if (access && !hit)             miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (fill) replay_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      replay_q   <= replay_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-back write-allocate data cache (tag/data arrays, hit path)
// Optional DCACHE_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] memaddra,
  input  logic [31:0] memwdata,
  output logic [31:0] rdata,
  output logic        stall,
  dcache_dm_if.master mem
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WSEL_W = word_sel_w(WORDS);
  localparam int IDX_W  = index_w(LINES);
  localparam int OFF_W  = offset_w(WORDS);
  localparam int TAG_W  = tag_w(LINES, WORDS);
  localparam int LINE_W = line_w(WORDS);

  logic [WSEL_W-1:0] word_sel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_byte_sel;

  assign word_sel        = memaddra[2 +: WSEL_W];
  assign idx             = memaddra[OFF_W +: IDX_W];
  assign req_tag         = memaddra[31 -: TAG_W];
  assign unused_byte_sel = ^memaddra[1:0];

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] data_d [LINES];

  state_e      state;
  logic        access, hit, in_idle, load_hit, store_hit, fill;
  logic [31:0] req_line_addr, victim_line_addr;

  // A simultaneous read+write strobe is a store.
  assign access    = memreadM | memwriteM;
  assign hit       = access && valid_q[idx] && (tag_q[idx] == req_tag);
  assign in_idle   = (state == ST_IDLE);
  assign load_hit  = in_idle && memreadM && !memwriteM && hit;
  assign store_hit = in_idle && memwriteM && hit;

  assign req_line_addr    = {memaddra[31:OFF_W], {OFF_W{1'b0}}};
  assign victim_line_addr = {tag_q[idx], idx, {OFF_W{1'b0}}};

  assign rdata = load_hit ? data_q[idx][{word_sel, 5'b0} +: 32] : 32'h0;
  assign stall = !in_idle || (access && !hit);

  // Victim data is read live; the array cannot change while WB is waiting for ack.
  assign mem.mem_wline = data_q[idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = req_tag;
      data_d[idx]  = mem.mem_rline;
    end
    if (store_hit) begin
      dirty_d[idx]                        = 1'b1;
      data_d[idx][{word_sel, 5'b0} +: 32] = memwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  dcache_ctrl u_ctrl (
    .clk              (clk),
    .rst              (rst),
    .access           (access),
    .hit              (hit),
    .victim_dirty     (valid_q[idx] && dirty_q[idx]),
    .req_line_addr    (req_line_addr),
    .victim_line_addr (victim_line_addr),
    .mem_ack          (mem.mem_ack),
    .state            (state),
    .mem_req          (mem.mem_req),
    .mem_we           (mem.mem_we),
    .mem_addr         (mem.mem_addr),
    .fill             (fill)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - self-checking bench for dcache_dm: directed table, corner sequences, randomized model
module tb_dcache_dm;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int LW    = 32 * WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [31:0] memaddra, memwdata, rdata;
  logic        stall;

  always #5 clk = ~clk;

  dcache_dm_if #(.WORDS(WORDS)) mem ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .memaddra  (memaddra),
    .memwdata  (memwdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem       (mem)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Main memory backing store; unwritten words follow a fixed hash pattern.
  logic [31:0] backing [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h0F0F1234;
  endfunction

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return init_word(a);
  endfunction

  int          fixed_delay = 2;
  int          inj_req = 0;
  int          inj_done = 0;
  int          n_wb = 0;
  int          n_refill = 0;
  logic [31:0] last_wb_addr = 32'h0;
  logic [31:0] last_refill_addr = 32'h0;
  logic        stab_bad = 1'b0;

  // Memory slave: acks each request after a (fixed or random) wait, records traffic,
  // and flags any change of the request fields while waiting.
  initial begin
    int          cnt;
    logic [31:0] a0;
    logic        w0;
    logic [LW-1:0] wl0, rl;
    backing[32'h100] = 32'h1;  backing[32'h104] = 32'h2;
    backing[32'h108] = 32'h3;  backing[32'h10C] = 32'h4;
    backing[32'h500] = 32'h50; backing[32'h504] = 32'h51;
    backing[32'h508] = 32'h52; backing[32'h50C] = 32'h53;
    mem.mem_ack   = 1'b0;
    mem.mem_rline = '0;
    cnt = -1;
    a0 = '0; w0 = 1'b0; wl0 = '0;
    forever begin
      @(negedge clk);
      mem.mem_ack = 1'b0;
      if (inj_req != inj_done && !mem.mem_req) begin
        inj_done      = inj_req;
        mem.mem_ack   = 1'b1;
        mem.mem_rline = {WORDS{32'hBAD0BAD0}};
      end else if (!mem.mem_req) begin
        cnt = -1;
      end else begin
        if (cnt < 0) begin
          cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
          a0  = mem.mem_addr;
          w0  = mem.mem_we;
          wl0 = mem.mem_wline;
        end else begin
          if (mem.mem_addr !== a0 || mem.mem_we !== w0 || (w0 && mem.mem_wline !== wl0))
            stab_bad = 1'b1;
        end
        if (cnt == 0) begin
          mem.mem_ack = 1'b1;
          if (w0) begin
            for (int w = 0; w < WORDS; w++) backing[a0 + 32'(4 * w)] = wl0[32*w +: 32];
            n_wb++;
            last_wb_addr = a0;
          end else begin
            for (int w = 0; w < WORDS; w++) rl[32*w +: 32] = back_rd(a0 + 32'(4 * w));
            mem.mem_rline = rl;
            n_refill++;
            last_refill_addr = a0;
          end
          cnt = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One core access held until stall drops; reports data and memory traffic it caused.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd_o, output int stall_cyc, output logic [31:0] rd_stall,
                           output int nwb, output logic [31:0] wba, output int nrf, output logic [31:0] rfa);
    int wb0, rf0;
    logic tmo;
    wb0 = n_wb; rf0 = n_refill; stall_cyc = 0; tmo = 1'b0; rd_stall = 32'h0;
    @(posedge clk); #1;
    memreadM = rd; memwriteM = wr; memaddra = a; memwdata = wd;
    forever begin
      @(negedge clk);
      if (!stall) break;
      if (stall_cyc == 0) rd_stall = rdata;
      stall_cyc++;
      if (stall_cyc > 500) begin tmo = 1'b1; break; end
    end
    rd_o = rdata;
    @(posedge clk); #1;
    memreadM = 1'b0; memwriteM = 1'b0;
    nwb = n_wb - wb0; wba = last_wb_addr;
    nrf = n_refill - rf0; rfa = last_refill_addr;
    check("access_timeout", {31'b0, tmo}, 32'h0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_wb;
    logic [31:0] exp_wb_addr;
    int          exp_rf;
    logic [31:0] exp_rf_addr;
  } vec_t;

  vec_t vecs [8];

  logic [31:0] arch_mem [logic [31:0]];
  logic        mvalid [LINES];
  logic        mdirty [LINES];
  logic [23:0] mtag   [LINES];

  initial begin
    logic [31:0] r, rs, wba, rfa;
    int          sc, nwb, nrf, found;

    // Clean miss = 2 + delay stall cycles, dirty miss = 3 + 2*delay (delay = 2 here).
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h1,        4, 0, 32'h0,   1, 32'h100};
    vecs[1] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h2,        0, 0, 32'h0,   0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h108, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,   0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h108, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,   0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h500, 32'h0,        32'h50,       7, 1, 32'h100, 1, 32'h500};
    vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h1,        4, 0, 32'h0,   1, 32'h100};
    vecs[6] = '{1'b1, 1'b1, 32'h10C, 32'h12345678, 32'h0,        0, 0, 32'h0,   0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h10C, 32'h0,        32'h12345678, 0, 0, 32'h0,   0, 32'h0};

    rst = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; memaddra = 32'h0; memwdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall",    {31'b0, stall},       32'h0);
    check("reset_mem_req",  {31'b0, mem.mem_req}, 32'h0);
    check("reset_mem_we",   {31'b0, mem.mem_we},  32'h0);
    check("reset_mem_addr", mem.mem_addr,          32'h0);
    check("reset_rdata",    rdata,                 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    fixed_delay = 2;
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, sc, rs, nwb, wba, nrf, rfa);
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall_cycles", i), 32'(sc), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_wb_count", i), 32'(nwb), 32'(vecs[i].exp_wb));
      check($sformatf("vec%0d_refill_count", i), 32'(nrf), 32'(vecs[i].exp_rf));
      if (vecs[i].exp_wb > 0) check($sformatf("vec%0d_wb_addr", i), wba, vecs[i].exp_wb_addr);
      if (vecs[i].exp_rf > 0) check($sformatf("vec%0d_refill_addr", i), rfa, vecs[i].exp_rf_addr);
      if (vecs[i].exp_stall > 0) check($sformatf("vec%0d_rdata_during_miss", i), rs, 32'h0);
    end
    check("wb_line_word2", back_rd(32'h108), 32'hDEADBEEF);
    check("wb_line_word0", back_rd(32'h100), 32'h1);

    // Stray ack while idle must not disturb the cache.
    inj_req++;
    repeat (3) @(posedge clk);
    do_access(1'b1, 1'b0, 32'h10C, 32'h0, r, sc, rs, nwb, wba, nrf, rfa);
    check("stray_ack_rdata", r, 32'h12345678);
    check("stray_ack_stall", 32'(sc), 32'h0);
    check("stray_ack_refill", 32'(nrf), 32'h0);

    // Reset in the second REFILL cycle of a dirty miss to 0x900 (same index as 0x100).
    fixed_delay = 20;
    found = 0;
    @(posedge clk); #1;
    memreadM = 1'b1; memaddra = 32'h900;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem.mem_req && !mem.mem_we) begin found = 1; break; end
    end
    check("refill_reached", 32'(found), 32'h1);
    check("refill_addr_900", mem.mem_addr, 32'h900);
    check("wb_before_refill", back_rd(32'h10C), 32'h12345678);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_req_held", {31'b0, mem.mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; memreadM = 1'b0;
    @(negedge clk);
    check("post_rst_mem_req", {31'b0, mem.mem_req}, 32'h0);
    check("post_rst_stall",   {31'b0, stall},       32'h0);
    fixed_delay = 2;
    do_access(1'b1, 1'b0, 32'h100, 32'h0, r, sc, rs, nwb, wba, nrf, rfa);
    check("post_rst_miss_stall", 32'(sc), 32'h4);
    check("post_rst_refill_addr", rfa, 32'h100);
    check("post_rst_rdata", r, 32'h1);

    // Randomized phase against an architectural memory model plus resident-tag model.
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fixed_delay = -1;
    arch_mem = backing;
    for (int l = 0; l < LINES; l++) begin mvalid[l] = 1'b0; mdirty[l] = 1'b0; mtag[l] = '0; end
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, wa, wd, exp_r, exp_wba;
      logic [23:0] t;
      int          ix, sel;
      logic        rdq, wrq, exp_hit, exp_wb;
      t   = 24'($urandom_range(0, 3));
      ix  = int'($urandom_range(0, 3));
      a   = {t, 4'(ix), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wa  = {a[31:2], 2'b00};
      wd  = $urandom;
      sel = int'($urandom_range(0, 9));
      rdq = (sel < 5) || (sel == 9);
      wrq = (sel >= 5);
      exp_hit = mvalid[ix] && (mtag[ix] == t);
      exp_wb  = !exp_hit && mvalid[ix] && mdirty[ix];
      exp_wba = {mtag[ix], 4'(ix), 4'h0};
      if (wrq) exp_r = 32'h0;
      else     exp_r = arch_mem.exists(wa) ? arch_mem[wa] : init_word(wa);
      do_access(rdq, wrq, a, wd, r, sc, rs, nwb, wba, nrf, rfa);
      check($sformatf("rnd%0d_rdata", n), r, exp_r);
      check($sformatf("rnd%0d_stalled", n), {31'b0, sc > 0}, {31'b0, !exp_hit});
      check($sformatf("rnd%0d_wb_count", n), 32'(nwb), {31'b0, exp_wb});
      check($sformatf("rnd%0d_refill_count", n), 32'(nrf), {31'b0, !exp_hit});
      if (exp_wb)   check($sformatf("rnd%0d_wb_addr", n), wba, exp_wba);
      if (!exp_hit) check($sformatf("rnd%0d_refill_addr", n), rfa, {a[31:4], 4'h0});
      if (wrq) arch_mem[wa] = wd;
      if (!exp_hit) begin mvalid[ix] = 1'b1; mtag[ix] = t; mdirty[ix] = 1'b0; end
      if (wrq) mdirty[ix] = 1'b1;
    end

    check("mem_fields_stable", {31'b0, stab_bad}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
